// File: rtl/crc_ahb_pkg.sv
// rtl/crc_ahb_pkg.sv - shared encodings for the crc_ip AHB-Lite initiator
package crc_ahb_pkg;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;

  localparam logic [31:0] OFS_DR   = 32'h0000_0000;
  localparam logic [31:0] OFS_CR   = 32'h0000_0008;
  localparam logic [31:0] OFS_INIT = 32'h0000_0010;
  localparam logic [31:0] OFS_POL  = 32'h0000_0014;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_INIT,
    ST_W_POL,
    ST_W_CR,
    ST_DATA,
    ST_RD_DR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ahb_single_xfer.sv
// rtl/ahb_single_xfer.sv - one non-overlapping AHB-Lite transfer at a time
module ahb_single_xfer
  import crc_ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        pending,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        error,
  output logic        HSElx,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  logic        dphase_q, dphase_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        err_q, err_d;
  logic        aphase;

  // An address phase is only ever driven when no data phase is outstanding.
  assign aphase  = req & ~dphase_q;
  assign pending = dphase_q;

  // Transfer-phase and captured-value registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dphase_q <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      dphase_q <= dphase_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      err_q    <= err_d;
    end
  end

  // Enter the data phase on an accepted address phase; leave it on HREADY.
  // Any ERROR cycle in the data phase is remembered until completion.
  always_comb begin
    dphase_d = dphase_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    err_d    = err_q;
    if (aphase && HREADY) begin
      dphase_d = 1'b1;
      haddr_d  = addr;
      hwdata_d = wdata;
      err_d    = 1'b0;
    end else if (dphase_q) begin
      err_d = err_q | HRESP;
      if (HREADY) begin
        dphase_d = 1'b0;
      end
    end
  end

  // Bus drive: address/control only during the address phase, write data held.
  always_comb begin
    HSElx  = aphase;
    HTRANS = aphase ? HTRANS_NONSEQ : HTRANS_IDLE;
    HADDR  = aphase ? addr : haddr_q;
    HWRITE = aphase & write;
    HSIZE  = HSIZE_WORD;
    HWDATA = hwdata_q;
    ack    = dphase_q & HREADY;
    rdata  = HRDATA;
    error  = dphase_q & HREADY & (err_q | HRESP);
  end

endmodule

// File: rtl/crc_ahb_master.sv
// rtl/crc_ahb_master.sv - programs crc_ip, streams words into DR, reads the result
module crc_ahb_master
  import crc_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] RESET_CR  = 32'h0000_0001
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [31:0] cfg_init,
  input  logic [31:0] cfg_pol,
  input  logic [31:0] cfg_cr,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] crc_out,
  output logic        err,
  output logic        HSElx,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  state_e      state_q, state_d;
  logic [31:0] init_q, init_d;
  logic [31:0] pol_q, pol_d;
  logic [31:0] cr_q, cr_d;
  logic [31:0] crc_q, crc_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic        x_req, x_write, x_pending, x_ack, x_error;
  logic [31:0] x_addr, x_wdata, x_rdata;
  logic        accept;
  logic        handshake;

  assign accept    = start & (state_q == ST_IDLE);
  assign handshake = in_valid & in_ready;
  assign crc_out   = crc_q;
  assign err       = err_q;

  ahb_single_xfer u_xfer (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .req     (x_req),
    .addr    (x_addr),
    .write   (x_write),
    .wdata   (x_wdata),
    .pending (x_pending),
    .ack     (x_ack),
    .rdata   (x_rdata),
    .error   (x_error),
    .HSElx   (HSElx),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HSIZE   (HSIZE),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .HRESP   (HRESP)
  );

  // State and datapath registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      init_q  <= '0;
      pol_q   <= '0;
      cr_q    <= '0;
      crc_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      pol_q   <= pol_d;
      cr_q    <= cr_d;
      crc_q   <= crc_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Sequence the register programming, the word stream and the result read;
  // an errored transfer short-circuits straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_W_INIT;
      ST_W_INIT: if (x_ack) state_d = x_error ? ST_DONE : ST_W_POL;
      ST_W_POL:  if (x_ack) state_d = x_error ? ST_DONE : ST_W_CR;
      ST_W_CR:   if (x_ack) state_d = x_error ? ST_DONE : ST_DATA;
      ST_DATA:   if (x_ack) state_d = x_error ? ST_DONE : (last_q ? ST_RD_DR : ST_DATA);
      ST_RD_DR:  if (x_ack) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-state transfer request and client-facing handshake/status.
  always_comb begin
    x_req    = 1'b0;
    x_addr   = BASE_ADDR + OFS_DR;
    x_write  = 1'b0;
    x_wdata  = '0;
    in_ready = 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    case (state_q)
      ST_W_INIT: begin
        x_req   = 1'b1;
        x_addr  = BASE_ADDR + OFS_INIT;
        x_write = 1'b1;
        x_wdata = init_q;
      end
      ST_W_POL: begin
        x_req   = 1'b1;
        x_addr  = BASE_ADDR + OFS_POL;
        x_write = 1'b1;
        x_wdata = pol_q;
      end
      ST_W_CR: begin
        x_req   = 1'b1;
        x_addr  = BASE_ADDR + OFS_CR;
        x_write = 1'b1;
        x_wdata = cr_q | RESET_CR;
      end
      ST_DATA: begin
        in_ready = HREADY & ~x_pending;
        x_req    = in_valid;
        x_write  = 1'b1;
        x_wdata  = in_data;
      end
      ST_RD_DR: begin
        x_req = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Configuration capture, last-word tracking, sticky error and result capture.
  always_comb begin
    init_d = init_q;
    pol_d  = pol_q;
    cr_d   = cr_q;
    crc_d  = crc_q;
    last_d = last_q;
    err_d  = err_q;
    if (accept) begin
      init_d = cfg_init;
      pol_d  = cfg_pol;
      cr_d   = cfg_cr;
      err_d  = 1'b0;
    end
    if (handshake) begin
      last_d = in_last;
    end
    if (x_ack && x_error) begin
      err_d = 1'b1;
    end
    if ((state_q == ST_RD_DR) && x_ack && !x_error) begin
      crc_d = x_rdata;
    end
  end

endmodule

// File: tb/tb_crc_ahb_master.sv
// tb/tb_crc_ahb_master.sv - directed table-driven bench for crc_ahb_master
module tb_crc_ahb_master;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic [31:0] cfg_init, cfg_pol, cfg_cr;
  logic [31:0] in_data;
  logic        in_valid, in_last;
  logic        in_ready, busy, done, err;
  logic [31:0] crc_out;
  logic        HSElx, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADY, HRESP;

  always #5 HCLK = ~HCLK;

  crc_ahb_master #(.BASE_ADDR(BASE), .RESET_CR(32'h0000_0001)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start),
    .cfg_init(cfg_init), .cfg_pol(cfg_pol), .cfg_cr(cfg_cr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .busy(busy), .done(done), .crc_out(crc_out), .err(err),
    .HSElx(HSElx), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // ---------------- slave model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       log_q[$];
  logic        slv_clear = 1'b0;
  int          ws_tbl[16];
  int          err_idx_cfg = -1;
  logic [31:0] rd_val = '0;
  logic        dp_q = 1'b0;
  logic [31:0] dp_addr = '0;
  logic        dp_wr = 1'b0;
  logic        dp_err = 1'b0;
  logic        dp_first = 1'b0;
  int          dp_wcnt = 0;
  int          xfer_idx = 0;
  logic [31:0] stab_wdata = '0;
  int          stab_bad = 0;

  assign HREADY = !dp_q || (dp_wcnt == 0);
  assign HRESP  = dp_q && dp_err;
  assign HRDATA = (dp_q && !dp_wr) ? rd_val : 32'h0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_q <= 1'b0;
    end else begin
      if (slv_clear) begin
        log_q.delete();
        xfer_idx <= 0;
        stab_bad <= 0;
      end
      if (dp_q) begin
        if (HTRANS != 2'b00) stab_bad <= stab_bad + 1;
        if (dp_first) begin
          stab_wdata <= HWDATA;
          dp_first   <= 1'b0;
        end else if (dp_wr && HWDATA !== stab_wdata) begin
          stab_bad <= stab_bad + 1;
        end
        if (dp_wcnt == 0) begin
          log_q.push_back('{dp_addr, dp_wr, HWDATA});
          dp_q <= 1'b0;
        end else begin
          dp_wcnt <= dp_wcnt - 1;
        end
      end
      if (HSElx && HTRANS == 2'b10 && HREADY) begin
        dp_q     <= 1'b1;
        dp_first <= 1'b1;
        dp_addr  <= HADDR;
        dp_wr    <= HWRITE;
        dp_err   <= (xfer_idx == err_idx_cfg);
        dp_wcnt  <= (xfer_idx == err_idx_cfg) ? 1 : ((xfer_idx < 16) ? ws_tbl[xfer_idx] : 0);
        xfer_idx <= xfer_idx + 1;
      end
    end
  end

  int done_cnt = 0;
  always @(negedge HCLK) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_HSElx"}, HSElx, 0);
    chk({tag, "_HTRANS"}, HTRANS, 0);
    chk({tag, "_HADDR"}, HADDR, 0);
    chk({tag, "_HWRITE"}, HWRITE, 0);
    chk({tag, "_HWDATA"}, HWDATA, 0);
    chk({tag, "_HSIZE"}, HSIZE, 3'b010);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_crc_out"}, crc_out, 0);
  endtask

  typedef struct {
    logic [31:0] init, pol, cr;
    int          n;
    logic [31:0] w[4];
    int          gap_word, gap_len;
    int          ws_idx0, ws0, ws_idx1, ws1;
    int          err_idx;
    int          restart_cyc;
    logic [31:0] rd_val;
    int          exp_cycle;
    logic        exp_err;
    int          exp_consumed;
    logic [31:0] exp_crc;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int vi);
    vec_t  v;
    int    cyc, ptr, gapc, dc0;
    bit    got, hs;
    xfer_t e[$];
    v = vecs[vi];
    for (int k = 0; k < 16; k++) ws_tbl[k] = 0;
    if (v.ws_idx0 >= 0) ws_tbl[v.ws_idx0] = v.ws0;
    if (v.ws_idx1 >= 0) ws_tbl[v.ws_idx1] = v.ws1;
    err_idx_cfg = v.err_idx;
    rd_val = v.rd_val;
    dc0 = done_cnt;
    @(negedge HCLK);
    start = 1'b1; cfg_init = v.init; cfg_pol = v.pol; cfg_cr = v.cr; slv_clear = 1'b1;
    @(posedge HCLK);
    cyc = 0; ptr = 0; gapc = 0; got = 0;
    while (cyc < 200 && !got) begin
      @(negedge HCLK);
      cyc++;
      slv_clear = 1'b0;
      start = (cyc == v.restart_cyc);
      if (start) begin
        cfg_init = 32'hDEAD_0000; cfg_pol = 32'hBEEF_0000; cfg_cr = 32'h0000_00F0;
      end
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      if (ptr == v.gap_word && gapc < v.gap_len) begin
        gapc++;
        #1 chk($sformatf("v%0d_gap%0d_htrans_idle", vi, gapc), HTRANS, 2'b00);
      end else if (ptr < v.n) begin
        in_valid = 1'b1; in_data = v.w[ptr]; in_last = (ptr == v.n - 1);
      end
      #1;
      if (cyc == 1) chk($sformatf("v%0d_busy_rise", vi), busy, 1);
      if (done === 1'b1) begin
        got = 1;
      end else begin
        hs = in_valid && in_ready;
        @(posedge HCLK);
        if (hs) ptr++;
      end
    end
    chk($sformatf("v%0d_done_seen", vi), got, 1);
    if (got) begin
      chk($sformatf("v%0d_done_cycle", vi), cyc, v.exp_cycle);
      chk($sformatf("v%0d_err", vi), err, v.exp_err);
      chk($sformatf("v%0d_crc_out", vi), crc_out, v.exp_crc);
      chk($sformatf("v%0d_busy_in_done", vi), busy, 1);
    end
    chk($sformatf("v%0d_words_consumed", vi), ptr, v.exp_consumed);
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    repeat (4) @(negedge HCLK);
    #1;
    e.push_back('{BASE + 32'h10, 1'b1, v.init});
    e.push_back('{BASE + 32'h14, 1'b1, v.pol});
    e.push_back('{BASE + 32'h08, 1'b1, v.cr | 32'h1});
    for (int k = 0; k < v.exp_consumed; k++) e.push_back('{BASE, 1'b1, v.w[k]});
    if (!v.exp_err) e.push_back('{BASE, 1'b0, 32'h0});
    chk($sformatf("v%0d_xfer_count", vi), log_q.size(), e.size());
    for (int k = 0; k < e.size() && k < log_q.size(); k++) begin
      chk($sformatf("v%0d_x%0d_addr", vi, k), log_q[k].addr, e[k].addr);
      chk($sformatf("v%0d_x%0d_write", vi, k), log_q[k].wr, e[k].wr);
      if (e[k].wr) chk($sformatf("v%0d_x%0d_wdata", vi, k), log_q[k].data, e[k].data);
    end
    chk($sformatf("v%0d_stable_dphase", vi), stab_bad, 0);
    chk($sformatf("v%0d_one_done", vi), done_cnt - dc0, 1);
    chk($sformatf("v%0d_idle_after", vi), busy, 0);
    chk($sformatf("v%0d_err_held", vi), err, v.exp_err);
    chk($sformatf("v%0d_crc_held", vi), crc_out, v.exp_crc);
  endtask

  initial begin
    int dc0;
    //        init          pol           cr    n  words                                          gw gl wi0 ws0 wi1 ws1 err rs rd_val       cyc er cons exp_crc
    vecs[0] = '{32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h0, 1, '{32'h1234_5678, 32'h0, 32'h0, 32'h0},   -1, 0, -1, 0, -1, 0, -1, 0, 32'hDF8A_8A2B, 11, 1'b0, 1, 32'hDF8A_8A2B};
    vecs[1] = '{32'h0000_0000, 32'h1EDC_6F41, 32'h20, 4, '{32'h1, 32'h2, 32'h3, 32'h4},          2, 3, -1, 0, -1, 0, -1, 0, 32'hCAFE_F00D, 19, 1'b0, 4, 32'hCAFE_F00D};
    vecs[2] = '{32'h1111_1111, 32'h04C1_1DB7, 32'h0, 1, '{32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0},   -1, 0,  1, 2,  4, 2, -1, 0, 32'h0BAD_BEEF, 15, 1'b0, 1, 32'h0BAD_BEEF};
    vecs[3] = '{32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h4, 3, '{32'h11, 32'h22, 32'h33, 32'h0},        -1, 0, -1, 0, -1, 0,  4, 0, 32'h5555_5555, 12, 1'b1, 2, 32'h0BAD_BEEF};
    vecs[4] = '{32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h0, 1, '{32'h1234_5678, 32'h0, 32'h0, 32'h0},   -1, 0, -1, 0, -1, 0, -1, 5, 32'hDF8A_8A2B, 11, 1'b0, 1, 32'hDF8A_8A2B};

    HRESET = 1'b1; start = 1'b0; cfg_init = '0; cfg_pol = '0; cfg_cr = '0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    #1 check_reset("por");
    HRESET = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i);

    // reset during the POL data phase
    @(negedge HCLK);
    start = 1'b1; cfg_init = 32'hFFFF_FFFF; cfg_pol = 32'h04C1_1DB7; cfg_cr = '0; slv_clear = 1'b1;
    err_idx_cfg = -1;
    for (int k = 0; k < 16; k++) ws_tbl[k] = 0;
    @(posedge HCLK);
    @(negedge HCLK);
    start = 1'b0; slv_clear = 1'b0;
    repeat (3) @(negedge HCLK);
    #1;
    chk("mid_pol_dphase_hwdata", HWDATA, 32'h04C1_1DB7);
    chk("mid_pol_dphase_htrans", HTRANS, 2'b00);
    dc0 = done_cnt;
    HRESET = 1'b1;
    @(negedge HCLK);
    #1 check_reset("midrst");
    HRESET = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("midrst_no_done", done_cnt - dc0, 0);
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
